// File: rtl/ets_sweep_sequencer.sv
// ets_sweep_sequencer: steps a phase-delay code across [first, last], waiting for lock and settle before each capture.
// Optional lock timeout: define ETS_LOCK_TIMEOUT_EN to enable it (otherwise lock_error is tied low).
module ets_sweep_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] first_delay,
    input  logic [7:0] last_delay,
    input  logic [7:0] step_size,
    input  logic       lock,
    input  logic       capture_done,
    output logic [7:0] delay,
    output logic       capture_start,
    output logic       busy,
    output logic       sweep_done,
    output logic       lock_error
);

    localparam int unsigned CODE_W       = 8;
    localparam int unsigned SETTLE_W     = 8;
    localparam int unsigned GUARD_CYCLES = 2;

    // Elaboration-time parameter sanity checks
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..255");
    end
    if (LOCK_TIMEOUT <= GUARD_CYCLES) begin : g_bad_timeout
        $error("LOCK_TIMEOUT must exceed the lock blanking window");
    end

    typedef enum logic [2:0] {
        IDLE,
        SET,
        WAIT_LOCK,
        SETTLE,
        CAPTURE,
        WAIT_CAP,
        ADVANCE,
        DONE
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   last_q;
    logic [CODE_W-1:0]   step_q;
    logic [1:0]          guard_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [CODE_W:0]     next_code;

`ifdef ETS_LOCK_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign lock_error = 1'b0;
`endif

    // Ninth bit keeps codes past 255 from wrapping back into range
    assign next_code = {1'b0, code} + {1'b0, (step_q == '0) ? CODE_W'(1) : step_q};

    // Sweep FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            code          <= '0;
            last_q        <= '0;
            step_q        <= '0;
            guard_cnt     <= '0;
            settle_cnt    <= '0;
            delay         <= '0;
            capture_start <= 1'b0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
`ifdef ETS_LOCK_TIMEOUT_EN
            tmo_cnt       <= '0;
            lock_error    <= 1'b0;
`endif
        end else begin
            capture_start <= 1'b0;
            sweep_done    <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            code   <= first_delay;
                            last_q <= last_delay;
                            step_q <= step_size;
                            delay  <= first_delay;
                            busy   <= 1'b1;
                            state  <= SET;
`ifdef ETS_LOCK_TIMEOUT_EN
                            lock_error <= 1'b0;
`endif
                        end
                    end
                    SET: begin
                        guard_cnt <= '0;
                        state     <= WAIT_LOCK;
`ifdef ETS_LOCK_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                    // Lock is blanked for the first cycles so a stale lock is not trusted
                    WAIT_LOCK: begin
                        if (guard_cnt != 2'(GUARD_CYCLES)) begin
                            guard_cnt <= guard_cnt + 2'd1;
                        end
                        if (guard_cnt == 2'(GUARD_CYCLES) && lock) begin
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
`ifdef ETS_LOCK_TIMEOUT_EN
                        else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                            lock_error <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
`endif
                    end
                    SETTLE: begin
                        if (!lock) begin
                            settle_cnt <= '0;
                            guard_cnt  <= '0;
                            state      <= WAIT_LOCK;
                        end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                            capture_start <= 1'b1;
                            state         <= CAPTURE;
                        end else begin
                            settle_cnt <= settle_cnt + SETTLE_W'(1);
                        end
                    end
                    CAPTURE: begin
                        state <= WAIT_CAP;
                    end
                    WAIT_CAP: begin
                        if (capture_done) begin
                            state <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        if (next_code > {1'b0, last_q}) begin
                            sweep_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            code  <= next_code[CODE_W-1:0];
                            delay <= next_code[CODE_W-1:0];
                            state <= SET;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ets_sweep_sequencer.sv
// tb_ets_sweep_sequencer: directed and randomized sweeps checked against a list-based model of the sweep.
// Define ETS_LOCK_TIMEOUT_EN for both bench and RTL to exercise the lock timeout.
module tb_ets_sweep_sequencer;

    localparam int unsigned SETTLE        = 16;
    localparam int unsigned TIMEOUT       = 1024;
    // WAIT_LOCK blanks lock for 2 cycles and samples it on the 3rd
    localparam int unsigned LOCK_WAIT_MIN = 3;
    // start cycle -> accept edge, SET, lock wait, SETTLE, CAPTURE entry
    localparam int unsigned FIRST_CAP_LAT = 1 + LOCK_WAIT_MIN + SETTLE + 1;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b1;
    logic       start        = 1'b0;
    logic       abort        = 1'b0;
    logic [7:0] first_delay  = '0;
    logic [7:0] last_delay   = '0;
    logic [7:0] step_size    = '0;
    logic       lock         = 1'b1;
    logic       capture_done = 1'b0;
    logic [7:0] delay;
    logic       capture_start;
    logic       busy;
    logic       sweep_done;
    logic       lock_error;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int unsigned cyc      = 0;
    int unsigned start_cyc = 0;
    int unsigned ret_cyc  = 0;
    int          cap_lat  = 3;
    int          done_cnt = 0;
    logic        prev_cs  = 1'b0;
    logic        prev_sd  = 1'b0;
    logic [7:0]  cap_q[$];
    int unsigned cap_cyc_q[$];
    logic [7:0]  exp_q[$];

    ets_sweep_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .first_delay   (first_delay),
        .last_delay    (last_delay),
        .step_size     (step_size),
        .lock          (lock),
        .capture_done  (capture_done),
        .delay         (delay),
        .capture_start (capture_start),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .lock_error    (lock_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observe pulses between edges
    always @(negedge clk) begin
        if (capture_start) begin
            check_eq("capture_start_one_cycle", 32'(prev_cs), 32'd0);
            cap_q.push_back(delay);
            cap_cyc_q.push_back(cyc);
        end
        if (sweep_done) begin
            check_eq("sweep_done_one_cycle", 32'(prev_sd), 32'd0);
            done_cnt++;
        end
        prev_cs = capture_start;
        prev_sd = sweep_done;
    end

    // Capture engine: answers each capture_start cap_lat cycles later
    initial forever begin
        @(negedge clk);
        if (capture_start) begin
            repeat (cap_lat - 1) @(negedge clk);
            capture_done = 1'b1;
            @(negedge clk);
            capture_done = 1'b0;
        end
    end

    // Reference: every code from first in steps of max(step,1), bounded by last and 255; always at least first
    task automatic make_expected(input int f, input int l, input int s);
        int st;
        st = (s == 0) ? 1 : s;
        exp_q.delete();
        exp_q.push_back(8'(f));
        for (int c = f + st; c <= l && c <= 255; c += st) exp_q.push_back(8'(c));
    endtask

    task automatic pulse_start(input int f, input int l, input int s);
        @(negedge clk);
        cap_q.delete();
        cap_cyc_q.delete();
        done_cnt    = 0;
        first_delay = 8'(f);
        last_delay  = 8'(l);
        step_size   = 8'(s);
        start       = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start       = 1'b0;
        first_delay = 8'($urandom);
        last_delay  = 8'($urandom);
        step_size   = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget, input bit start_in_done);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
            if (start_in_done && sweep_done) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n++;
            end
        end
        check_eq({tag, "_reaches_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic finish_sweep(input string tag, input bit chk_lat, input bit start_in_done);
        wait_idle(tag, 20000, start_in_done);
        repeat (4) @(negedge clk);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_n_captures"}, 32'(cap_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            check_eq($sformatf("%s_code%0d", tag, i),
                     (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        check_eq({tag, "_sweep_done_count"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_delay_hold"}, 32'(delay), 32'(exp_q[$]));
        check_eq({tag, "_lock_error"}, 32'(lock_error), 32'd0);
        if (chk_lat && cap_cyc_q.size() > 0)
            check_eq({tag, "_first_latency"}, 32'(cap_cyc_q[0] - start_cyc), 32'(FIRST_CAP_LAT));
    endtask

    task automatic run_sweep(input string tag, input int f, input int l, input int s, input bit start_in_done);
        make_expected(f, l, s);
        pulse_start(f, l, s);
        finish_sweep(tag, 1'b1, start_in_done);
    endtask

    initial begin
        int n;
        #2 reset_n = 1'b0;
        #1;
        check_eq("reset_delay", 32'(delay), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_capture_start", 32'(capture_start), 32'd0);
        check_eq("reset_sweep_done", 32'(sweep_done), 32'd0);
        check_eq("reset_lock_error", 32'(lock_error), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_after_reset", 32'(busy), 32'd0);

        // Directed sweeps; the first also raises start while in DONE, which must be ignored
        cap_lat = 3;
        run_sweep("basic", 10, 40, 10, 1'b1);
        cap_lat = 4;
        run_sweep("near_255", 250, 255, 4, 1'b0);
        run_sweep("step_zero", 5, 7, 0, 1'b0);
        run_sweep("reversed", 9, 3, 20, 1'b0);
        run_sweep("top_code", 255, 255, 1, 1'b0);

        // Lock glitch mid-SETTLE restarts lock qualification and the full settle count
        cap_lat = 3;
        make_expected(77, 77, 5);
        pulse_start(77, 77, 5);
        n = 0;
        while (cyc < start_cyc + 11 && n < 50) begin
            @(negedge clk);
            n++;
        end
        lock = 1'b0;
        @(negedge clk);
        lock    = 1'b1;
        ret_cyc = cyc;
        finish_sweep("lock_drop", 1'b0, 1'b0);
        if (cap_cyc_q.size() > 0)
            check_eq("lock_drop_capture_delay", 32'(cap_cyc_q[0] - ret_cyc), 32'(LOCK_WAIT_MIN + SETTLE));

`ifdef ETS_LOCK_TIMEOUT_EN
        lock = 1'b0;
        pulse_start(33, 33, 1);
        n = 0;
        while (busy && n < int'(TIMEOUT) + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_busy", 32'(busy), 32'd0);
        check_eq("timeout_cycle", 32'(cyc - start_cyc), 32'(1 + 1 + TIMEOUT));
        check_eq("timeout_lock_error", 32'(lock_error), 32'd1);
        check_eq("timeout_no_done", 32'(done_cnt), 32'd0);
        check_eq("timeout_no_capture", 32'(cap_q.size()), 32'd0);
        lock = 1'b1;
        run_sweep("after_timeout", 33, 35, 1, 1'b0);
`else
        lock = 1'b0;
        pulse_start(33, 33, 1);
        repeat (TIMEOUT + 80) @(negedge clk);
        check_eq("no_timeout_busy", 32'(busy), 32'd1);
        check_eq("no_timeout_lock_error", 32'(lock_error), 32'd0);
        check_eq("no_timeout_no_capture", 32'(cap_q.size()), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        lock  = 1'b1;
        check_eq("no_timeout_abort_busy", 32'(busy), 32'd0);
`endif

        // Abort while waiting for capture_done
        cap_lat = 40;
        pulse_start(20, 60, 20);
        n = 0;
        while (cap_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_first_capture", 32'(cap_q.size()), 32'd1);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (50) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        check_eq("abort_no_more_capture", 32'(cap_q.size()), 32'd1);
        check_eq("abort_stays_idle", 32'(busy), 32'd0);
        cap_lat = 3;
        run_sweep("after_abort", 20, 60, 20, 1'b0);

        // Asynchronous reset mid-sweep
        pulse_start(100, 200, 50);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midreset_busy", 32'(busy), 32'd0);
        check_eq("midreset_delay", 32'(delay), 32'd0);
        check_eq("midreset_capture_start", 32'(capture_start), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("midreset_no_done", 32'(done_cnt), 32'd0);
        check_eq("midreset_stays_idle", 32'(busy), 32'd0);
        run_sweep("after_reset", 100, 200, 50, 1'b0);

        // Randomized sweeps
        for (int t = 0; t < 12; t++) begin
            int f, l, s, st;
            f  = int'($urandom_range(0, 255));
            s  = int'($urandom_range(0, 30));
            st = (s == 0) ? 1 : s;
            if ($urandom_range(0, 3) == 0) l = int'($urandom_range(0, f));
            else l = f + int'($urandom_range(0, st * 8));
            if (l > 255) l = 255;
            cap_lat = int'($urandom_range(2, 6));
            run_sweep($sformatf("rnd%0d", t), f, l, s, (t % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
